seq_pattern_tx: RTL and testbench

SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

---
 rtl/seq_tx_pkg.sv | 23 ++
 rtl/seq_pattern_tx_tick_gen.sv | 32 +++
 rtl/seq_pattern_tx.sv | 120 ++++++++++++
 tb/tb_seq_pattern_tx.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/seq_tx_pkg.sv
// Shared types and constants for the serial pattern transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package seq_tx_pkg;

  // Index and count widths are sized for the largest supported frame (16 bits)
  // and the 4-bit repeat input.
  localparam int BIT_IDX_W   = 4;
  localparam int FRAME_CNT_W = 4;

  localparam logic [4:0] DEFAULT_PATTERN = 5'b10010;

  localparam logic [1:0] ST_IDLE_ENC = 2'b00;
  localparam logic [1:0] ST_SEND_ENC = 2'b01;
  localparam logic [1:0] ST_DONE_ENC = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_SEND = ST_SEND_ENC,
    ST_DONE = ST_DONE_ENC
  } seq_state_e;

endpackage

// File: rtl/seq_pattern_tx_tick_gen.sv
// Bit-period divider: pulses tick for one cycle out of every DIV cycles.
// Latency: first tick DIV cycles after clr (clr forces the count to 0).
// Backpressure: none; free-running counter.
//
// Ports: clk, reset (sync, active high), clr (restart the period), tick (out).
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int             CW   = $clog2(DIV);
  localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial frame-burst transmitter: sends PATTERN MSB first, rpt+1 frames back to back.
// Latency: first bit on w the cycle after start is accepted; done one cycle after last bit.
// Backpressure: none; start is only honoured in IDLE, otherwise dropped (never queued).
//
// Ports: clk, reset (sync, active high), start, rpt[3:0] (frames-1) in;
//        w, w_valid, busy, done, state[1:0] (debug) out.
// Build option: define SEQ_TX_TICK_DIV_EN to hold each bit for DIV cycles
// (tick_gen divider); otherwise every bit lasts one cycle and DIV is unused.
module seq_pattern_tx
  import seq_tx_pkg::*;
#(
  parameter int                 PAT_LEN = 5,
  parameter logic [PAT_LEN-1:0] PATTERN = DEFAULT_PATTERN,
  parameter int                 DIV     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] rpt,
  output logic       w,
  output logic       w_valid,
  output logic       busy,
  output logic       done,
  output logic [1:0] state
);

  if (PAT_LEN < 2 || PAT_LEN > 16 || DIV < 2) begin : g_param_err
    $error("seq_pattern_tx: PAT_LEN must be 2..16 and DIV at least 2");
  end

  localparam logic [BIT_IDX_W-1:0] LAST_IDX = BIT_IDX_W'(PAT_LEN - 1);

  seq_state_e             state_q,     state_d;
  logic [BIT_IDX_W-1:0]   bit_idx_q,   bit_idx_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                   accept;
  logic                   tick;

  assign accept = (state_q == ST_IDLE) && start;

`ifdef SEQ_TX_TICK_DIV_EN
  // Restarting the divider on acceptance makes the first bit a full DIV cycles.
  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .tick  (tick)
  );
`else
  assign tick = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_idx_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    frame_cnt_d = frame_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_SEND;
          bit_idx_d   = '0;
          frame_cnt_d = rpt;  // rpt is latched here; later changes are ignored
        end
      end
      ST_SEND: begin
        if (tick) begin
          if (bit_idx_q == LAST_IDX) begin
            bit_idx_d = '0;
            if (frame_cnt_q != '0) begin
              frame_cnt_d = frame_cnt_q - 1'b1;  // next frame, no gap
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;  // 2'b11 recovers to IDLE
      end
    endcase
  end

  // Bit index 0 selects the pattern MSB; a compare loop avoids an
  // oversized variable bit-select into PATTERN.
  always_comb begin
    w = 1'b0;
    if (state_q == ST_SEND) begin
      for (int i = 0; i < PAT_LEN; i++) begin
        if (bit_idx_q == BIT_IDX_W'(PAT_LEN - 1 - i)) begin
          w = PATTERN[i];
        end
      end
    end
  end

  assign w_valid = (state_q == ST_SEND);
  assign busy    = (state_q == ST_SEND);
  assign done    = (state_q == ST_DONE);
  assign state   = state_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx with the default 5-bit pattern 10010.
// Cycle k is the interval after the k-th rising edge following the start request.
// Works with or without SEQ_TX_TICK_DIV_EN (bit period T = DIV or 1).
module tb_seq_pattern_tx;

`ifdef SEQ_TX_TICK_DIV_EN
  localparam int T = 4;
`else
  localparam int T = 1;
`endif
  localparam int PAT_LEN = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] rpt;
  logic       w;
  logic       w_valid;
  logic       busy;
  logic       done;
  logic [1:0] state;

  int n_checks = 0;
  int n_errors = 0;

  logic [PAT_LEN-1:0] pat_v;

  seq_pattern_tx #(
    .PAT_LEN (PAT_LEN),
    .PATTERN (5'b10010),
    .DIV     (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .rpt     (rpt),
    .w       (w),
    .w_valid (w_valid),
    .busy    (busy),
    .done    (done),
    .state   (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to 1 time unit after the next rising edge; inputs and samples happen there.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " state"},   32'(state),   32'd0);
    check({tag, " w"},       32'(w),       32'd0);
    check({tag, " w_valid"}, 32'(w_valid), 32'd0);
    check({tag, " busy"},    32'(busy),    32'd0);
    check({tag, " done"},    32'(done),    32'd0);
  endtask

  // Called in cycle 1 of a burst; checks every bit cycle and ends in the DONE cycle.
  // mid_start pulses start during cycle 3; rpt_chg rewrites rpt during cycle 2.
  task automatic check_burst(input string tag, input int frames,
                             input bit mid_start, input bit rpt_chg);
    int n;
    int idx;
    n = frames * PAT_LEN * T;
    for (int c = 1; c <= n; c++) begin
      idx = ((c - 1) / T) % PAT_LEN;
      check({tag, " w"},       32'(w),       32'(pat_v[PAT_LEN-1-idx]));
      check({tag, " w_valid"}, 32'(w_valid), 32'd1);
      check({tag, " busy"},    32'(busy),    32'd1);
      check({tag, " state"},   32'(state),   32'd1);
      check({tag, " done"},    32'(done),    32'd0);
      if (mid_start) start = (c == 3);
      if (rpt_chg && c == 2) rpt = 4'd7;
      step();
    end
    check({tag, " done pulse"},   32'(done),    32'd1);
    check({tag, " done state"},   32'(state),   32'd2);
    check({tag, " done busy"},    32'(busy),    32'd0);
    check({tag, " done w_valid"}, 32'(w_valid), 32'd0);
    check({tag, " done w"},       32'(w),       32'd0);
  endtask

  initial begin
    pat_v = 5'b10010;
    reset = 1'b1;
    start = 1'b0;
    rpt   = 4'd0;
    step();
    step();
    check_idle("reset");
    reset = 1'b0;
    step();
    check_idle("post-reset idle");

    // Single frame: w = 1,0,0,1,0 then done.
    rpt = 4'd0; start = 1'b1;
    step();
    start = 1'b0;
    check_burst("rpt0", 1, 1'b0, 1'b0);
    step();
    check_idle("rpt0 after done");

    // Two frames back to back, rpt changed mid-burst must be ignored.
    rpt = 4'd1; start = 1'b1;
    step();
    start = 1'b0;
    check_burst("rpt1", 2, 1'b0, 1'b1);
    step();
    check_idle("rpt1 after done");

    // start pulse mid-burst is dropped: same waveform as a single frame.
    rpt = 4'd0; start = 1'b1;
    step();
    start = 1'b0;
    check_burst("midstart", 1, 1'b1, 1'b0);
    step();
    check_idle("midstart after done");
    step();
    check_idle("midstart no requeue");

    // Reset in cycle 3 of a burst: IDLE in cycle 4 and no done afterwards.
    rpt = 4'd2; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check("rst pre busy", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_idle("rst cycle4");
    begin
      int done_seen;
      done_seen = 0;
      for (int i = 0; i < 20; i++) begin
        if (done) done_seen++;
        step();
      end
      check("rst no done", 32'(done_seen), 32'd0);
    end

    // Reset beats start in the same cycle.
    start = 1'b1; reset = 1'b1;
    step();
    reset = 1'b0; start = 1'b0;
    check_idle("rst over start");

    // start held high: bursts 1..5T and after one IDLE cycle, again.
    rpt = 4'd0; start = 1'b1;
    step();
    check_burst("held1", 1, 1'b0, 1'b0);
    step();
    check_idle("held gap");
    step();
    check_burst("held2", 1, 1'b0, 1'b0);
    start = 1'b0;
    step();
    check_idle("held end");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
